// File: rtl/if_buf_writer_if.sv
// if_buf_writer_if
//  Bundles the two handshakes of the IF buffer writer: the element stream
//  coming from the IF source and the write port of the IF buffer FIFO.
//  master : the writer (accepts elements, drives framed FIFO writes)
//  slave  : the environment (source + FIFO)
//  src_valid/src_data/src_ready    element handshake
//  IF_buf_full/IF_buf_write/IF_buf_wdata  FIFO write port, word {start,end,data}
interface if_buf_writer_if #(
  parameter int IF_SCRATCH_WIDTH = 16
);
  logic                        src_valid;
  logic [IF_SCRATCH_WIDTH-1:0] src_data;
  logic                        src_ready;
  logic                        IF_buf_full;
  logic                        IF_buf_write;
  logic [IF_SCRATCH_WIDTH+1:0] IF_buf_wdata;

  modport master (
    input  src_valid, src_data, IF_buf_full,
    output src_ready, IF_buf_write, IF_buf_wdata
  );

  modport slave (
    output src_valid, src_data, IF_buf_full,
    input  src_ready, IF_buf_write, IF_buf_wdata
  );
endinterface

// File: rtl/if_buf_writer.sv
// if_buf_writer
//  Producer side of the IF buffer protocol. Packs a raw element stream into
//  framed words {start_flag, end_flag, data} for the IF FIFO; start_flag marks
//  the first element of a row, end_flag the last.
//  clk, rst        clock / synchronous active-high reset
//  start           1-cycle pulse, latches row_len/row_count and opens a frame
//  row_len         elements per row (0 -> start ignored)
//  row_count       rows per frame   (0 -> start ignored)
//  bus             element stream in, framed FIFO writes out
//  busy            frame in progress
//  done            1-cycle pulse after the final word is written
module if_buf_writer #(
  parameter int IF_SCRATCH_WIDTH = 16,
  parameter int IF_ADDR_LEN      = 4,
  parameter int ROW_CNT_LEN      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [IF_ADDR_LEN-1:0] row_len,
  input  logic [ROW_CNT_LEN-1:0] row_count,
  if_buf_writer_if.master        bus,
  output logic                   busy,
  output logic                   done
);
  localparam int W = IF_SCRATCH_WIDTH;
  localparam logic [IF_ADDR_LEN-1:0] LEN_ONE = IF_ADDR_LEN'(1);
  localparam logic [ROW_CNT_LEN-1:0] ROW_ONE = ROW_CNT_LEN'(1);

  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

  state_t                 state_q, state_d;
  logic [IF_ADDR_LEN-1:0] len_q, len_d, elem_cnt_q, elem_cnt_d;
  logic [ROW_CNT_LEN-1:0] rows_q, rows_d, row_cnt_q, row_cnt_d;
  logic [W+1:0]           stg_q, stg_d;
  logic                   stg_valid_q, stg_valid_d;

  logic streaming, exhausted, ready, accept, wr, wr_done, last_elem;

  always_comb begin
    streaming = (state_q == STREAM);
    // every row of the frame has been accepted; only the staged word remains
    exhausted = (row_cnt_q == rows_q);
    // the single staging slot can take a new element if it is empty or
    // is being drained this very cycle
    ready     = streaming & ~exhausted & (~stg_valid_q | ~bus.IF_buf_full);
    accept    = bus.src_valid & ready;
    wr        = streaming & stg_valid_q;
    wr_done   = wr & ~bus.IF_buf_full;
    last_elem = (elem_cnt_q == len_q - LEN_ONE);

    state_d     = state_q;
    len_d       = len_q;
    rows_d      = rows_q;
    elem_cnt_d  = elem_cnt_q;
    row_cnt_d   = row_cnt_q;
    stg_d       = stg_q;
    stg_valid_d = stg_valid_q;

    case (state_q)
      IDLE: begin
        if (start && row_len != '0 && row_count != '0) begin
          state_d     = STREAM;
          len_d       = row_len;
          rows_d      = row_count;
          elem_cnt_d  = '0;
          row_cnt_d   = '0;
          stg_valid_d = 1'b0;
        end
      end
      STREAM: begin
        if (wr_done) stg_valid_d = 1'b0;
        // a refill in the same cycle as a drain wins over the clear
        if (accept) begin
          stg_d       = {elem_cnt_q == '0, last_elem, bus.src_data};
          stg_valid_d = 1'b1;
          if (last_elem) begin
            elem_cnt_d = '0;
            row_cnt_d  = row_cnt_q + ROW_ONE;
          end else begin
            elem_cnt_d = elem_cnt_q + LEN_ONE;
          end
        end
        // once exhausted, the staged word is necessarily the frame's last
        if (wr_done && exhausted && stg_q[W]) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      rows_q      <= '0;
      elem_cnt_q  <= '0;
      row_cnt_q   <= '0;
      stg_q       <= '0;
      stg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rows_q      <= rows_d;
      elem_cnt_q  <= elem_cnt_d;
      row_cnt_q   <= row_cnt_d;
      stg_q       <= stg_d;
      stg_valid_q <= stg_valid_d;
    end
  end

  assign bus.src_ready    = ready;
  assign bus.IF_buf_write = wr;
  assign bus.IF_buf_wdata = stg_q;
  assign busy             = streaming;
  assign done             = (state_q == FIN);
endmodule

// File: tb/tb_if_buf_writer.sv
module tb_if_buf_writer;
  localparam int W  = 16;
  localparam int A  = 4;
  localparam int RC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [A-1:0]  row_len = '0;
  logic [RC-1:0] row_count = '0;
  logic          busy, done;

  if_buf_writer_if #(.IF_SCRATCH_WIDTH(W)) bus ();

  if_buf_writer #(
    .IF_SCRATCH_WIDTH(W), .IF_ADDR_LEN(A), .ROW_CNT_LEN(RC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len),
    .row_count(row_count), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, last_wr_cyc = 0;
  logic [W+1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: every completed FIFO write must be the next word of the model
  initial begin
    logic         prev_hold;
    logic [W+1:0] prev_wdata, w;
    prev_hold  = 1'b0;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) prev_hold = 1'b0;
      else begin
        if (prev_hold)
          chk("hold", {bus.IF_buf_write, bus.IF_buf_wdata}, {1'b1, prev_wdata});
        if (bus.IF_buf_write) begin
          chk("busy_wr", busy, 1);
          if (bus.IF_buf_full) chk("rdy_full", bus.src_ready, 0);
          else if (exp_q.size() == 0) chk("extra_wr", exp_q.size(), 1);
          else begin
            w = exp_q.pop_front();
            chk("wdata", bus.IF_buf_wdata, w);
            if (exp_q.size() == 0) last_wr_cyc = cyc;
          end
        end
        if (done) begin
          chk("done_time", cyc, last_wr_cyc + 1);
          chk("busy_done", busy, 0);
          done_cnt++;
        end
        prev_hold  = bus.IF_buf_write & bus.IF_buf_full;
        prev_wdata = bus.IF_buf_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int L, input int R);
    row_len   = A'(L);
    row_count = RC'(R);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // pv/pf: percent chance per cycle of src_valid / IF_buf_full
  task automatic run_frame(input int L, input int R, input int pv, input int pf, input bit poke);
    logic [W-1:0] d[$];
    int n, k, t, dc0;
    n = L * R; k = 0; t = 0; dc0 = done_cnt;
    for (int i = 0; i < n; i++) begin
      d.push_back(W'($urandom));
      exp_q.push_back({(i % L) == 0, (i % L) == (L - 1), d[i]});
    end
    pulse_start(L, R);
    while (k < n && t < 3000) begin
      bus.src_valid   = ($urandom_range(99) < pv);
      bus.src_data    = d[k];
      bus.IF_buf_full = ($urandom_range(99) < pf);
      if (poke && t == 2) begin
        start = 1'b1; row_len = A'($urandom); row_count = RC'($urandom);
      end else start = 1'b0;
      @(negedge clk);
      if (bus.src_valid && bus.src_ready) k++;
      tick();
      t++;
    end
    start = 1'b0;
    // leftover src_valid after the frame must be ignored
    while (done_cnt == dc0 && t < 3000) begin
      bus.src_valid   = 1'b1;
      bus.src_data    = W'($urandom);
      bus.IF_buf_full = ($urandom_range(99) < pf);
      tick();
      t++;
    end
    bus.src_valid   = 1'b0;
    bus.IF_buf_full = 1'b0;
    repeat (3) tick();
    chk("accepted", k, n);
    chk("done_cnt", done_cnt, dc0 + 1);
    chk("exp_empty", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    logic [W-1:0] d0, d1;
    int dc0;
    bus.src_valid = 1'b0; bus.src_data = '0; bus.IF_buf_full = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("reset_out", {bus.src_ready, bus.IF_buf_write, bus.IF_buf_wdata, busy, done}, 0);
    tick();
    rst = 1'b0;
    tick();

    run_frame(3, 2, 100, 0, 0);   // back-to-back
    run_frame(1, 4, 100, 0, 0);   // every word start+end
    run_frame(3, 2, 100, 40, 0);  // FIFO back-pressure
    run_frame(3, 2, 50, 0, 1);    // source gaps, start while streaming
    run_frame(15, 2, 80, 30, 0);  // max row length

    // reset in the middle of a row drops the staged word
    d0 = W'($urandom); d1 = W'($urandom);
    exp_q.push_back({1'b1, 1'b0, d0});
    pulse_start(3, 2);
    bus.src_valid = 1'b1; bus.src_data = d0;
    tick();
    bus.src_data = d1;
    tick();
    bus.src_valid = 1'b0; rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_out", {bus.src_ready, bus.IF_buf_write, bus.IF_buf_wdata, busy, done}, 0);
    chk("midrst_exp", exp_q.size(), 0);
    tick();
    rst = 1'b0;
    tick();
    run_frame(3, 2, 100, 0, 0);

    // zero-sized frames are ignored
    dc0 = done_cnt;
    pulse_start(0, 3);
    repeat (4) tick();
    chk("len0_busy", busy, 0);
    pulse_start(5, 0);
    repeat (4) tick();
    chk("cnt0_busy", busy, 0);
    chk("zero_done", done_cnt, dc0);

    for (int f = 0; f < 8; f++)
      run_frame($urandom_range(1, 15), $urandom_range(1, 3),
                $urandom_range(30, 100), $urandom_range(0, 60), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
